dram_resp: RTL and testbench

- Data-memory responder on the far end of the core's dram interface: word-organised storage that serves CPU reads and byte-enabled CPU writes.
- Also contains a byte-serial loader that fills memory while the CPU is held off the bus (ld_en_i high).
- Sits beside the core at SoC level. Connects to dram_rd_addr/dram_rd_data/dram_wr_addr/dram_wr_data/dram_wr_byte_en.

---
 rtl/hxd_mem_pkg.sv | 19 +
 rtl/dram_loader.sv | 99 +++++++++
 rtl/dram_resp.sv | 112 +++++++++++
 tb/tb_dram_resp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hxd_mem_pkg.sv
// Shared types and constants for the data-memory responder and its byte-serial loader.
package hxd_mem_pkg;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_COMMIT  = 2'd2
  } ld_state_t;

  localparam int         DRAM_BYTES_PER_WORD = 4;
  localparam logic [3:0] BYTE_EN_NONE        = 4'b0000;
  localparam logic [3:0] BYTE_EN_WORD        = 4'b1111;

  // One-hot lane select for byte position k within a word.
  function automatic logic [3:0] lane_bit(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/dram_loader.sv
// Byte-serial loader: assembles little-endian words and issues one array write per word.
module dram_loader
  import hxd_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld_en_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_ready_o,
  output logic [ADDR_W:0]   ld_word_cnt_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_byte_en_o
);

  ld_state_t         r_state, w_state_nxt;
  logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [3:0]        r_lane_en, w_lane_en_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [ADDR_W:0]   r_word_cnt, w_word_cnt_nxt;

  // Loader state and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= LD_IDLE;
      r_byte_cnt <= 2'd0;
      r_lane_en  <= BYTE_EN_NONE;
      r_word     <= 32'h0000_0000;
      r_waddr    <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_lane_en  <= w_lane_en_nxt;
      r_word     <= w_word_nxt;
      r_waddr    <= w_waddr_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  // Next-state, byte assembly and counter updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_lane_en_nxt  = r_lane_en;
    w_word_nxt     = r_word;
    w_waddr_nxt    = r_waddr;
    w_word_cnt_nxt = r_word_cnt;
    case (r_state)
      LD_IDLE: begin
        if (ld_en_i) begin
          w_state_nxt    = LD_COLLECT;
          w_byte_cnt_nxt = 2'd0;
          w_lane_en_nxt  = BYTE_EN_NONE;
          w_waddr_nxt    = '0;
          w_word_cnt_nxt = '0;
        end else begin
          w_state_nxt = LD_IDLE;
        end
      end
      LD_COLLECT: begin
        // A partially filled word is still flushed when the loader releases the bus.
        if (!ld_en_i) begin
          w_state_nxt = (r_lane_en != BYTE_EN_NONE) ? LD_COMMIT : LD_IDLE;
        end else if (ld_valid_i) begin
          w_word_nxt[{r_byte_cnt, 3'b000} +: 8] = ld_data_i;
          w_lane_en_nxt  = r_lane_en | lane_bit(r_byte_cnt);
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_state_nxt    = (r_byte_cnt == 2'd3) ? LD_COMMIT : LD_COLLECT;
        end else begin
          w_state_nxt = LD_COLLECT;
        end
      end
      LD_COMMIT: begin
        w_waddr_nxt    = r_waddr + ADDR_W'(1);
        w_word_cnt_nxt = (&r_word_cnt) ? r_word_cnt : r_word_cnt + (ADDR_W+1)'(1);
        w_byte_cnt_nxt = 2'd0;
        w_lane_en_nxt  = BYTE_EN_NONE;
        w_state_nxt    = ld_en_i ? LD_COLLECT : LD_IDLE;
      end
      default: begin
        w_state_nxt = LD_IDLE;
      end
    endcase
  end

  assign ld_ready_o    = (r_state == LD_COLLECT);
  assign ld_word_cnt_o = r_word_cnt;
  assign wr_en_o       = (r_state == LD_COMMIT);
  assign wr_addr_o     = r_waddr;
  assign wr_data_o     = r_word;
  assign wr_byte_en_o  = r_lane_en;

endmodule

// File: rtl/dram_resp.sv
// Data-memory responder: zero-latency CPU reads, byte-enabled CPU writes, and a loader
// that owns the array write port while ld_en_i is high or a loader commit is pending.
module dram_resp
  import hxd_mem_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               ADDR_W    = 10,
  parameter logic [XLEN-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [XLEN-1:0]   dram_rd_addr_i,
  output logic [XLEN-1:0]   dram_rd_data_o,
  input  logic [XLEN-1:0]   dram_wr_addr_i,
  input  logic [XLEN-1:0]   dram_wr_data_i,
  input  logic [3:0]        dram_wr_byte_en_i,
  input  logic              ld_en_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_ready_o,
  output logic [ADDR_W:0]   ld_word_cnt_o,
  output logic              addr_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [XLEN-1:0] SPAN = XLEN'(DRAM_BYTES_PER_WORD * DEPTH);

  logic [XLEN-1:0]   r_mem [DEPTH];
  logic              r_addr_err;

  logic [XLEN-1:0]   w_rd_off, w_wr_off;
  logic              w_rd_in, w_wr_in, w_cpu_wr;
  logic              w_ld_wr_en;
  logic [ADDR_W-1:0] w_ld_wr_addr, w_widx;
  logic [31:0]       w_ld_wr_data, w_wdata;
  logic [3:0]        w_ld_wr_be, w_wbe;
  logic              w_we;

  assign w_rd_off = dram_rd_addr_i - BASE_ADDR;
  assign w_wr_off = dram_wr_addr_i - BASE_ADDR;
  assign w_rd_in  = (w_rd_off < SPAN);
  assign w_wr_in  = (w_wr_off < SPAN);
  assign w_cpu_wr = (dram_wr_byte_en_i != BYTE_EN_NONE);

  dram_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ld_en_i       (ld_en_i),
    .ld_valid_i    (ld_valid_i),
    .ld_data_i     (ld_data_i),
    .ld_ready_o    (ld_ready_o),
    .ld_word_cnt_o (ld_word_cnt_o),
    .wr_en_o       (w_ld_wr_en),
    .wr_addr_o     (w_ld_wr_addr),
    .wr_data_o     (w_ld_wr_data),
    .wr_byte_en_o  (w_ld_wr_be)
  );

  // Read mux: the core samples this in the same cycle, so it stays combinational.
  always_comb begin
    dram_rd_data_o = '0;
    if (rst_n_i && !ld_en_i && w_rd_in) begin
      dram_rd_data_o = r_mem[w_rd_off[ADDR_W+1:2]];
    end else begin
      dram_rd_data_o = '0;
    end
  end

  // Array write-port arbitration: a pending loader commit wins over the CPU.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = '0;
    w_wdata = 32'h0000_0000;
    w_wbe   = BYTE_EN_NONE;
    if (w_ld_wr_en) begin
      w_we    = 1'b1;
      w_widx  = w_ld_wr_addr;
      w_wdata = w_ld_wr_data;
      w_wbe   = w_ld_wr_be;
    end else if (!ld_en_i && w_wr_in && w_cpu_wr) begin
      w_we    = 1'b1;
      w_widx  = w_wr_off[ADDR_W+1:2];
      w_wdata = dram_wr_data_i[31:0];
      w_wbe   = dram_wr_byte_en_i;
    end else begin
      w_we = 1'b0;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int i = 0; i < DRAM_BYTES_PER_WORD; i++) begin
        if (w_wbe[i]) begin
          r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Sticky out-of-range flag for CPU accesses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr_err <= 1'b0;
    end else if (!ld_en_i && (!w_rd_in || (!w_wr_in && w_cpu_wr))) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err_o = r_addr_err;

endmodule

// File: tb/tb_dram_resp.sv
// Directed-plus-random bench for dram_resp against a word-array reference model.
module tb_dram_resp;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_MAX = 2 ** (ADDR_W + 1) - 1;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [31:0]       dram_rd_addr_i, dram_rd_data_o;
  logic [31:0]       dram_wr_addr_i, dram_wr_data_i;
  logic [3:0]        dram_wr_byte_en_i;
  logic              ld_en_i, ld_valid_i, ld_ready_o, addr_err_o;
  logic [7:0]        ld_data_i;
  logic [ADDR_W:0]   ld_word_cnt_o;

  always #5 clk_i = ~clk_i;

  dram_resp #(.XLEN(32), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .dram_rd_addr_i    (dram_rd_addr_i),
    .dram_rd_data_o    (dram_rd_data_o),
    .dram_wr_addr_i    (dram_wr_addr_i),
    .dram_wr_data_i    (dram_wr_data_i),
    .dram_wr_byte_en_i (dram_wr_byte_en_i),
    .ld_en_i           (ld_en_i),
    .ld_valid_i        (ld_valid_i),
    .ld_data_i         (ld_data_i),
    .ld_ready_o        (ld_ready_o),
    .ld_word_cnt_o     (ld_word_cnt_o),
    .addr_err_o        (addr_err_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: memory as plain words, loader as a byte stream cut into words.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_word;
  logic [3:0]  m_lanes;
  int          m_nbytes, m_waddr, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic m_ld_start();
    m_nbytes = 0; m_waddr = 0; m_cnt = 0; m_lanes = 4'b0000; m_word = 32'h0;
  endtask

  task automatic m_commit();
    m_mem[m_waddr] = merge(m_mem[m_waddr], m_word, m_lanes);
    m_waddr = (m_waddr + 1) % DEPTH;
    if (m_cnt < CNT_MAX) m_cnt++;
    m_lanes = 4'b0000;
  endtask

  task automatic m_push(input logic [7:0] b);
    m_word[8*(m_nbytes % 4) +: 8] = b;
    m_lanes[m_nbytes % 4] = 1'b1;
    m_nbytes++;
    if (m_nbytes % 4 == 0) m_commit();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ld_begin();
    ld_en_i = 1'b1;
    m_ld_start();
    tick();
  endtask

  task automatic ld_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (!ld_ready_o && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("ld_ready_timeout", 32'(ld_ready_o), 32'd1);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    tick();
    ld_valid_i = 1'b0;
    m_push(b);
  endtask

  task automatic ld_end();
    ld_en_i = 1'b0;
    if (m_lanes != 4'b0000) m_commit();
    repeat (3) tick();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    dram_rd_addr_i = addr;
    #1;
    check(tag, dram_rd_data_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] last_word, wd;
    int          ridx, widx;
    logic [3:0]  be;

    rst_n_i = 1'b0;
    dram_rd_addr_i = 32'h0; dram_wr_addr_i = 32'h0; dram_wr_data_i = 32'h0;
    dram_wr_byte_en_i = 4'b0000;
    ld_en_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = 8'h00;
    m_ld_start();
    repeat (2) tick();
    check("rst_rd_data", dram_rd_data_o, 32'h0);
    check("rst_ld_ready", 32'(ld_ready_o), 32'd0);
    check("rst_word_cnt", 32'(ld_word_cnt_o), 32'd0);
    check("rst_addr_err", 32'(addr_err_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Eight-byte load into words 0 and 1.
    ld_begin();
    for (int i = 1; i <= 8; i++) begin
      ld_byte(8'(i * 8'h11));
      if (i % 4 == 0) check("ready_low_after_4th", 32'(ld_ready_o), 32'd0);
    end
    ld_end();
    read_chk("load8_w0", 32'h0, 32'h4433_2211);
    read_chk("load8_w1", 32'h4, 32'h8877_6655);
    check("load8_cnt", 32'(ld_word_cnt_o), 32'd2);

    // Partial word over an all-ones word.
    dram_wr_addr_i = 32'h0; dram_wr_data_i = 32'hFFFF_FFFF; dram_wr_byte_en_i = 4'b1111;
    tick();
    m_mem[0] = 32'hFFFF_FFFF;
    dram_wr_byte_en_i = 4'b0000;
    ld_begin();
    ld_byte(8'hAA); ld_byte(8'hBB); ld_byte(8'hCC);
    ld_end();
    read_chk("partial_w0", 32'h0, 32'hFFCC_BBAA);
    check("partial_cnt", 32'(ld_word_cnt_o), 32'd1);

    // Byte-enabled write and same-cycle read of the target word.
    dram_wr_addr_i = 32'h14; dram_wr_data_i = 32'h0; dram_wr_byte_en_i = 4'b1111;
    tick();
    m_mem[5] = 32'h0;
    dram_wr_data_i = 32'hDEAD_BEEF; dram_wr_byte_en_i = 4'b0101;
    read_chk("same_cycle_old", 32'h14, 32'h0);
    tick();
    m_mem[5] = 32'h00AD_00EF;
    dram_wr_byte_en_i = 4'b0000;
    read_chk("be0101_result", 32'h14, 32'h00AD_00EF);

    // CPU blocked while the loader owns the memory.
    ld_en_i = 1'b1;
    dram_wr_addr_i = 32'h14; dram_wr_data_i = 32'h1234_5678; dram_wr_byte_en_i = 4'b1111;
    read_chk("blocked_rd_zero", 32'h14, 32'h0);
    m_ld_start();
    tick();
    read_chk("blocked_rd_zero2", 32'h14, 32'h0);
    dram_wr_byte_en_i = 4'b0000;
    ld_en_i = 1'b0;
    repeat (2) tick();
    read_chk("blocked_unchanged", 32'h14, m_mem[5]);
    check("blocked_cnt", 32'(ld_word_cnt_o), 32'(m_cnt));

    // Out-of-range accesses and the sticky error flag.
    dram_wr_addr_i = 32'(4 * DEPTH); dram_wr_byte_en_i = 4'b0000;
    tick();
    check("oor_be0_noflag", 32'(addr_err_o), 32'd0);
    read_chk("oor_rd_zero", 32'(4 * DEPTH), 32'h0);
    tick();
    check("oor_flag_set", 32'(addr_err_o), 32'd1);
    dram_rd_addr_i = 32'h0;
    repeat (3) tick();
    check("oor_flag_sticky", 32'(addr_err_o), 32'd1);

    // DEPTH+1 words: the last one wraps onto word 0.
    ld_begin();
    last_word = 32'h0;
    for (int w = 0; w <= DEPTH; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        last_word[8*k +: 8] = b;
        ld_byte(b);
      end
    end
    ld_end();
    check("wrap_cnt", 32'(ld_word_cnt_o), 32'(DEPTH + 1));
    read_chk("wrap_w0", 32'h0, last_word);
    for (int i = 0; i < 8; i++) begin
      ridx = $urandom_range(1, DEPTH - 1);
      read_chk("wrap_spot", 32'(ridx * 4), m_mem[ridx]);
    end

    // Random CPU traffic over a small window so reads and writes collide.
    for (int i = 0; i < 300; i++) begin
      widx = $urandom_range(0, 15);
      ridx = $urandom_range(0, 15);
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      dram_wr_addr_i    = 32'(widx * 4) | 32'($urandom_range(0, 3));
      dram_wr_data_i    = wd;
      dram_wr_byte_en_i = be;
      read_chk("rand_rd", 32'(ridx * 4) | 32'($urandom_range(0, 3)), m_mem[ridx]);
      tick();
      m_mem[widx] = merge(m_mem[widx], wd, be);
    end
    dram_wr_byte_en_i = 4'b0000;

    // Reset in the middle of a word: nothing is written.
    ld_begin();
    ld_byte(8'h5A); ld_byte(8'hA5);
    rst_n_i = 1'b0;
    #1;
    check("midrst_ready", 32'(ld_ready_o), 32'd0);
    check("midrst_cnt", 32'(ld_word_cnt_o), 32'd0);
    check("midrst_err", 32'(addr_err_o), 32'd0);
    check("midrst_rd_gated", dram_rd_data_o, 32'h0);
    m_lanes = 4'b0000;
    repeat (2) tick();
    ld_en_i = 1'b0;
    rst_n_i = 1'b1;
    tick();
    check("postrst_ready", 32'(ld_ready_o), 32'd0);
    read_chk("postrst_w0", 32'h0, m_mem[0]);
    ld_en_i = 1'b1;
    tick();
    check("postrst_collect", 32'(ld_ready_o), 32'd1);
    ld_en_i = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
